// File: rtl/sb_pkg.sv
// Shared types for the store buffer: size encodings, default depth and the queued entry layout.
// Coalescing of same-word stores is enabled by defining STORE_BUF_COALESCE_EN.
package sb_pkg;

    localparam int SB_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } sb_size_e;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] pc;
    } sb_entry_t;

    // Byte-wise overlay of a new lane-aligned store onto older entry data
    function automatic logic [31:0] sb_merge(input logic [31:0] old_data,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  new_be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = new_be[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Combinational store lane alignment: size + low address bits -> byte enables and replicated data.
module sb_lane_align
    import sb_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [3:0]  be_o,
    output logic [31:0] data_o
);

    // Misaligned halves/words drop the offending low address bits; unknown size acts as a word
    always_comb begin
        be_o   = 4'h0;
        data_o = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                be_o   = 4'b0001 << addr_lo_i;
                data_o = {4{data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                data_o = {2{data_i[15:0]}};
            end
            default: begin
                be_o   = 4'hF;
                data_o = data_i;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO write-back store buffer with load/store word-conflict detection.
// Define STORE_BUF_COALESCE_EN to merge a store into the youngest entry on a word match.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        dm_valid,
    input  logic        dm_ready,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        ent_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic        full_s, drain_s, enq_s, alloc_s, coal_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_data_s;
    sb_entry_t   new_ent_s;
    logic        unused_s;

    assign unused_s = ^ld_addr[1:0];

    sb_lane_align u_align (
        .size_i    (st_size),
        .addr_lo_i (st_addr[1:0]),
        .data_i    (st_data),
        .be_o      (al_be_s),
        .data_o    (al_data_s)
    );

    assign new_ent_s = '{addr: st_addr[31:2], be: al_be_s, data: al_data_s, pc: st_pc};
    assign full_s    = (cnt_q == CW'(DEPTH));
    assign dm_valid  = (cnt_q != {CW{1'b0}});
    assign empty     = ~dm_valid;
    assign drain_s   = dm_valid & dm_ready;

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] young_s;
    assign young_s = tail_q - PW'(1);

    // Merge only into the youngest live entry, never into a head that leaves this cycle
    always_comb begin
        coal_s = st_valid & vld_q[young_s] & (ent_q[young_s].addr == st_addr[31:2])
                 & ~(drain_s & (young_s == head_q));
    end
`else
    assign coal_s = 1'b0;
`endif

    assign st_ready = ~full_s | coal_s;
    assign enq_s    = st_valid & st_ready;
    assign alloc_s  = enq_s & ~coal_s;

    // Pointer and occupancy next-state
    always_comb begin
        head_d = drain_s ? head_q + PW'(1) : head_q;
        tail_d = alloc_s ? tail_q + PW'(1) : tail_q;
        case ({alloc_s, drain_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Entry storage, valid bits and pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= {PW{1'b0}};
            tail_q <= {PW{1'b0}};
            cnt_q  <= {CW{1'b0}};
            vld_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (drain_s) begin
                vld_q[head_q] <= 1'b0;
            end
            if (alloc_s) begin
                vld_q[tail_q] <= 1'b1;
                ent_q[tail_q] <= new_ent_s;
            end
`ifdef STORE_BUF_COALESCE_EN
            if (enq_s && coal_s) begin
                ent_q[young_s].be   <= ent_q[young_s].be | al_be_s;
                ent_q[young_s].data <= sb_merge(ent_q[young_s].data, al_data_s, al_be_s);
                ent_q[young_s].pc   <= st_pc;
            end
`endif
        end
    end

    // Head presentation; zeros while nothing is pending
    always_comb begin
        if (dm_valid) begin
            dm_addr  = {ent_q[head_q].addr, 2'b00};
            dm_be    = ent_q[head_q].be;
            dm_wdata = ent_q[head_q].data;
            dm_pc    = ent_q[head_q].pc;
        end else begin
            dm_addr  = 32'h0;
            dm_be    = 4'h0;
            dm_wdata = 32'h0;
            dm_pc    = 32'h0;
        end
    end

    // Same-word hazard against every pending entry; the incoming store is not considered
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_conflict = ld_conflict | (ld_valid & vld_q[i] & (ent_q[i].addr == ld_addr[31:2]));
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected memory writes are queued at issue and checked by a monitor.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset, st_valid, st_ready, ld_valid, ld_conflict;
    logic        dm_valid, dm_ready, empty;
    logic [1:0]  st_size;
    logic [31:0] st_addr, st_data, st_pc, ld_addr, dm_addr, dm_wdata, dm_pc;
    logic [3:0]  dm_be;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_pc(dm_pc), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                            input logic [31:0] pc);
        wr_t w;
        w.addr = a; w.be = be; w.data = d; w.pc = pc;
        exp_q.push_back(w);
    endtask

    // Monitor: every memory write handshake must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && dm_valid && dm_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h be %h data 0x%08h", dm_addr, dm_be, dm_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", dm_addr, w.addr);
                chk("wr_be", {28'h0, dm_be}, {28'h0, w.be});
                chk("wr_data", dm_wdata, w.data);
                chk("wr_pc", dm_pc, w.pc);
            end
        end
    end

    // Called just after a rising edge; holds the store until it is accepted
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] pc);
        logic ok;
        ok = 1'b0;
        st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d; st_pc = pc;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = st_ready;
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: addr 0x%08h never accepted", a);
        end
    endtask

    task automatic wait_empty();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = empty;
        end
        chk("drain_to_empty", {31'h0, ok}, 32'h1);
        @(posedge clk); #1;
    endtask

    int cyc;

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_size = 2'd0; st_addr = 32'h0; st_data = 32'h0;
        st_pc = 32'h0; ld_valid = 1'b0; ld_addr = 32'h0; dm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
        chk("rst_dm_valid", {31'h0, dm_valid}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_ld_conflict", {31'h0, ld_conflict}, 32'h0);
        chk("rst_dm_addr", dm_addr, 32'h0);
        chk("rst_dm_be", {28'h0, dm_be}, 32'h0);
        chk("rst_dm_wdata", dm_wdata, 32'h0);
        chk("rst_dm_pc", dm_pc, 32'h0);
        @(posedge clk); #1;

        // First store: one-cycle latency, no bypass
        push_exp(32'h10, 4'hF, 32'h12345678, 32'h100);
        st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h10; st_data = 32'h12345678; st_pc = 32'h100;
        @(negedge clk);
        chk("no_bypass_dm_valid", {31'h0, dm_valid}, 32'h0);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("lat1_dm_valid", {31'h0, dm_valid}, 32'h1);
        chk("lat1_dm_addr", dm_addr, 32'h10);
        chk("lat1_empty", {31'h0, empty}, 32'h0);
        @(posedge clk); #1;
        dm_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_drain_empty", {31'h0, empty}, 32'h1);
        @(posedge clk); #1;

        // Lane alignment, including misaligned half/word
        push_exp(32'h10, 4'b1000, 32'hABABABAB, 32'h104);
        do_store(2'd0, 32'h13, 32'h000000AB, 32'h104);
        push_exp(32'h20, 4'b1100, 32'hBEEFBEEF, 32'h108);
        do_store(2'd1, 32'h22, 32'h0000BEEF, 32'h108);
        push_exp(32'h20, 4'b0011, 32'h12341234, 32'h10C);
        do_store(2'd1, 32'h21, 32'hFFFF1234, 32'h10C);
        push_exp(32'h104, 4'hF, 32'hCAFEF00D, 32'h110);
        do_store(2'd2, 32'h107, 32'hCAFEF00D, 32'h110);
        push_exp(32'h30, 4'b0010, 32'h5A5A5A5A, 32'h114);
        do_store(2'd0, 32'h31, 32'h1234565A, 32'h114);
        wait_empty();

        // Fill to full, hold a fifth store, then drain at full rate
        dm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'(i * 4), 4'hF, 32'hA0 + 32'(i), 32'h200 + 32'(i * 4));
            do_store(2'd2, 32'(i * 4), 32'hA0 + 32'(i), 32'h200 + 32'(i * 4));
        end
        push_exp(32'h30, 4'hF, 32'hA4, 32'h210);
        st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h30; st_data = 32'hA4; st_pc = 32'h210;
        repeat (2) begin
            @(negedge clk);
            chk("full_st_ready", {31'h0, st_ready}, 32'h0);
            @(posedge clk); #1;
        end
        dm_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        chk("full_draining_st_ready", {31'h0, st_ready}, 32'h0);
        cyc += dm_valid ? 1 : 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_st_ready", {31'h0, st_ready}, 32'h1);
        cyc += dm_valid ? 1 : 0;
        @(posedge clk); #1;
        st_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cyc += dm_valid ? 1 : 0;
        end
        chk("drain_cycles", 32'(cyc), 32'd5);
        @(posedge clk); #1;

        // Load conflict against a pending word
        dm_ready = 1'b0;
        push_exp(32'h40, 4'hF, 32'h40404040, 32'h300);
        do_store(2'd2, 32'h40, 32'h40404040, 32'h300);
        ld_valid = 1'b1; ld_addr = 32'h42;
        @(negedge clk);
        chk("ld_hit", {31'h0, ld_conflict}, 32'h1);
        ld_addr = 32'h44;
        #1 chk("ld_miss_next_word", {31'h0, ld_conflict}, 32'h0);
        ld_valid = 1'b0; ld_addr = 32'h40;
        #1 chk("ld_not_valid", {31'h0, ld_conflict}, 32'h0);
        ld_valid = 1'b1;
        @(posedge clk); #1;
        dm_ready = 1'b1;
        @(negedge clk);
        chk("ld_hit_while_draining", {31'h0, ld_conflict}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld_clear_after_drain", {31'h0, ld_conflict}, 32'h0);

        // Store in the same cycle as the load is not compared
        @(posedge clk); #1;
        dm_ready = 1'b0;
        ld_addr = 32'h80;
        push_exp(32'h80, 4'hF, 32'h80808080, 32'h304);
        st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h80; st_data = 32'h80808080; st_pc = 32'h304;
        @(negedge clk);
        chk("ld_same_cycle_store", {31'h0, ld_conflict}, 32'h0);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("ld_hit_next_cycle", {31'h0, ld_conflict}, 32'h1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        dm_ready = 1'b1;
        wait_empty();

        // Two byte stores into one word
        dm_ready = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        push_exp(32'h50, 4'b0011, 32'h11112211, 32'h404);
`else
        push_exp(32'h50, 4'b0001, 32'h11111111, 32'h400);
        push_exp(32'h50, 4'b0010, 32'h22222222, 32'h404);
`endif
        do_store(2'd0, 32'h50, 32'h11, 32'h400);
        do_store(2'd0, 32'h51, 32'h22, 32'h404);
        @(negedge clk);
`ifdef STORE_BUF_COALESCE_EN
        chk("coal_head_be", {28'h0, dm_be}, 32'h3);
`else
        chk("nocoal_head_be", {28'h0, dm_be}, 32'h1);
`endif
        @(posedge clk); #1;
        dm_ready = 1'b1;
        wait_empty();

        // Reset mid-drain discards pending stores
        dm_ready = 1'b0;
        do_store(2'd2, 32'h60, 32'h60, 32'h500);
        do_store(2'd2, 32'h64, 32'h64, 32'h504);
        do_store(2'd2, 32'h68, 32'h68, 32'h508);
        reset = 1'b1; dm_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_dm_valid", {31'h0, dm_valid}, 32'h0);
        chk("mid_rst_empty", {31'h0, empty}, 32'h1);
        chk("mid_rst_st_ready", {31'h0, st_ready}, 32'h1);
        chk("mid_rst_dm_be", {28'h0, dm_be}, 32'h0);
        repeat (5) @(posedge clk);
        #1;

        chk("pending_expected_writes", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
